multi_axis_bcd_sampler: RTL

- Periodically snapshots CHANNELS signed sensor samples, such as accelerometer X/Y/Z, in one clock cycle.
- Converts each sample to sign plus DIGITS-digit BCD using a sequential shift-add-3 (double-dabble) engine, one channel at a time.
- Publishes all channels atomically as stable registers for the seven-segment decoders, VGA number generators and PWM duty logic.
- Replaces the combinational divide/modulo digit extraction and the separate slow-refresh latch.

---
 rtl/multi_axis_bcd_sampler.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_axis_bcd_sampler.sv
// multi_axis_bcd_sampler
//
// Periodically captures CHANNELS signed samples (for example accelerometer
// X/Y/Z) in a single clock cycle. Each sample is then converted to
// sign + DIGITS-digit BCD with a sequential shift-add-3 (double-dabble)
// engine, one channel at a time. All channels are published together, so
// downstream display logic always sees one coherent frame.
//
// Ports
//   clk           system clock (single domain)
//   rst           synchronous, active-high reset
//   sample_in     CHANNELS*IN_W packed two's-complement samples; ch0 in LSBs
//   force_update  single-cycle request for an immediate conversion frame
//   bcd_out       CHANNELS*DIGITS*4 packed BCD; channel c, digit d at
//                 [(c*DIGITS+d)*4 +: 4]; d=0 is the units digit
//   sign_out      per channel: 1 = sample was negative
//   ovf_out       per channel: 1 = magnitude above 10^DIGITS-1, digits held at 9
//   busy          high while a frame is being converted
//   frame_valid   one-cycle pulse on the cycle the outputs update
//
// Build option
//   MULTI_AXIS_BCD_BLANK_EN  when defined, leading zeros are replaced by
//                            4'hF at commit. The units digit and saturated
//                            channels are never blanked. When undefined,
//                            leading zeros stay 4'h0 and no blanking logic
//                            exists.
//
// Frame timing: a trigger edge captures the snapshot. Then every channel
// takes 1 LOAD + IN_W SHIFT + 1 STORE cycles. frame_valid is therefore high
// CHANNELS*(IN_W+2) cycles after the trigger edge.

module multi_axis_bcd_sampler #(
  parameter int CHANNELS       = 3,
  parameter int IN_W           = 16,
  parameter int DIGITS         = 5,
  parameter int REFRESH_CYCLES = 50_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*IN_W-1:0]       sample_in,
  input  logic                           force_update,
  output logic [CHANNELS*DIGITS*4-1:0]   bcd_out,
  output logic [CHANNELS-1:0]            sign_out,
  output logic [CHANNELS-1:0]            ovf_out,
  output logic                           busy,
  output logic                           frame_valid
);

  localparam int BCD_W  = DIGITS * 4;
  localparam int WORK_W = BCD_W + IN_W;
  localparam int OUT_W  = CHANNELS * BCD_W;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int BC_W   = $clog2(IN_W + 1);

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  // Two's-complement absolute value as an unsigned IN_W-bit number. The most
  // negative input maps to +2^(IN_W-1), which still fits once read unsigned.
  function automatic logic [IN_W-1:0] abs_mag(input logic signed [IN_W-1:0] s);
    logic [IN_W-1:0] u;
    u = $unsigned(s);
    return s[IN_W-1] ? (~u + IN_W'(1)) : u;
  endfunction

  // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
  // the whole {bcd, magnitude} register left by one. The MSB of the result
  // is the bit that fell out of the top digit, which signals overflow.
  function automatic logic [WORK_W:0] dabble_step(input logic [WORK_W-1:0] r);
    logic [WORK_W-1:0] a;
    a = r;
    for (int d = 0; d < DIGITS; d++) begin
      if (a[IN_W + d*4 +: 4] >= 4'd5)
        a[IN_W + d*4 +: 4] = a[IN_W + d*4 +: 4] + 4'd3;
    end
    return {a, 1'b0};
  endfunction

  // Saturation: a channel that overflowed shows all nines.
  function automatic logic [BCD_W-1:0] saturate(input logic [BCD_W-1:0] b,
                                                input logic             ovf);
    return ovf ? {DIGITS{4'h9}} : b;
  endfunction

`ifdef MULTI_AXIS_BCD_BLANK_EN
  // Replaces zeros above the most significant nonzero digit with 4'hF. The
  // scan stops above the units digit, so a zero value still shows "0".
  function automatic logic [OUT_W-1:0] blank_leading(input logic [OUT_W-1:0]    b,
                                                     input logic [CHANNELS-1:0] ovf);
    logic [OUT_W-1:0] o;
    logic             lead;
    o = b;
    for (int c = 0; c < CHANNELS; c++) begin
      lead = !ovf[c];
      for (int d = DIGITS - 1; d >= 1; d--) begin
        if (b[(c*DIGITS + d)*4 +: 4] != 4'h0)
          lead = 1'b0;
        if (lead)
          o[(c*DIGITS + d)*4 +: 4] = 4'hF;
      end
    end
    return o;
  endfunction
`endif

  // Control state
  logic [1:0]        state;
  logic [CH_W-1:0]   ch;
  logic [BC_W-1:0]   bit_cnt;
  logic              pending;
  logic              tick;
  logic              trigger;

  // Datapath
  logic [CHANNELS*IN_W-1:0] snap_p0;
  logic signed [IN_W-1:0]   cur_p0;
  logic [WORK_W-1:0]        work_p1;
  logic                     sign_p1;
  logic                     ovf_p1;
  logic [WORK_W:0]          step_p1;
  logic [OUT_W-1:0]         stage_bcd_p2;
  logic [CHANNELS-1:0]      stage_sign_p2;
  logic [CHANNELS-1:0]      stage_ovf_p2;
  logic [OUT_W-1:0]         stage_bcd_nxt;
  logic [CHANNELS-1:0]      stage_sign_nxt;
  logic [CHANNELS-1:0]      stage_ovf_nxt;
  logic [OUT_W-1:0]         commit_bcd;

  // Free-running refresh counter. It runs whatever the FSM is doing; a tick
  // that arrives while a frame is busy is simply ignored.
  generate
    if (REFRESH_CYCLES > 0) begin : g_refresh
      localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
      logic [CNT_W-1:0] refresh_cnt;

      always_ff @(posedge clk) begin
        if (rst)
          refresh_cnt <= '0;
        else if (refresh_cnt == CNT_LAST)
          refresh_cnt <= '0;
        else
          refresh_cnt <= refresh_cnt + CNT_W'(1);
      end

      assign tick = (refresh_cnt == CNT_LAST);
    end else begin : g_no_refresh
      assign tick = 1'b0;
    end
  endgenerate

  // ---- p0: trigger, snapshot and frame sequencing ----
  // A tick, a force request or a queued request can start a frame only in
  // IDLE. If several arrive together, they still start a single frame.
  assign trigger = (state == S_IDLE) && (tick || force_update || pending);
  assign cur_p0  = $signed(snap_p0[int'(ch)*IN_W +: IN_W]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ch          <= '0;
      bit_cnt     <= '0;
      pending     <= 1'b0;
      snap_p0     <= '0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      bcd_out     <= '0;
      sign_out    <= '0;
      ovf_out     <= '0;
    end else begin
      frame_valid <= 1'b0;

      // A force request during a frame is remembered once. Any further
      // requests before IDLE fold into the same flag.
      if ((state != S_IDLE) && force_update)
        pending <= 1'b1;
      else if (trigger)
        pending <= 1'b0;

      case (state)
        S_IDLE: begin
          if (trigger) begin
            snap_p0 <= sample_in;
            busy    <= 1'b1;
            ch      <= '0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          bit_cnt <= BC_W'(IN_W);
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          bit_cnt <= bit_cnt - BC_W'(1);
          if (bit_cnt == BC_W'(1))
            state <= S_STORE;
        end
        S_STORE: begin
          if (ch == CH_LAST) begin
            // Every channel switches on the same edge, so readers never
            // see a mix of old and new axes.
            bcd_out     <= commit_bcd;
            sign_out    <= stage_sign_nxt;
            ovf_out     <= stage_ovf_nxt;
            frame_valid <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            ch    <= ch + CH_W'(1);
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- p1: per-channel double-dabble conversion ----
  assign step_p1 = dabble_step(work_p1);

  always_ff @(posedge clk) begin
    case (state)
      S_LOAD: begin
        sign_p1 <= cur_p0[IN_W-1];
        work_p1 <= {{BCD_W{1'b0}}, abs_mag(cur_p0)};
        ovf_p1  <= 1'b0;
      end
      S_SHIFT: begin
        work_p1 <= step_p1[WORK_W-1:0];
        if (step_p1[WORK_W])
          ovf_p1 <= 1'b1;
      end
      default: begin
        work_p1 <= work_p1;
      end
    endcase
  end

  // ---- p2: staging and commit ----
  // The next staging image has the current channel merged in. On the last
  // channel the outputs load this image directly, so no extra cycle is
  // needed between the final STORE and the commit.
  always_comb begin
    stage_bcd_nxt  = stage_bcd_p2;
    stage_sign_nxt = stage_sign_p2;
    stage_ovf_nxt  = stage_ovf_p2;
    stage_bcd_nxt[int'(ch)*BCD_W +: BCD_W] = saturate(work_p1[WORK_W-1 -: BCD_W], ovf_p1);
    stage_sign_nxt[ch] = sign_p1;
    stage_ovf_nxt[ch]  = ovf_p1;
  end

  always_ff @(posedge clk) begin
    if (state == S_STORE) begin
      stage_bcd_p2  <= stage_bcd_nxt;
      stage_sign_p2 <= stage_sign_nxt;
      stage_ovf_p2  <= stage_ovf_nxt;
    end
  end

`ifdef MULTI_AXIS_BCD_BLANK_EN
  assign commit_bcd = blank_leading(stage_bcd_nxt, stage_ovf_nxt);
`else
  assign commit_bcd = stage_bcd_nxt;
`endif

endmodule
